iq_histogram: RTL and testbench

Downstream stage of `top_main`: consumes each demodulated readout point (`i_val`, `q_val` qualified by `iq_valid`) together with the binning configuration that `top_main` publishes. It maps the point to a 2D bin and accumulates a saturating count per bin in on-chip RAM. A host-side read port dumps the histogram; a clear sweep zeroes it.

---
 rtl/qubit_hist_pkg.sv | 30 +++
 rtl/hist_ram.sv | 25 ++
 rtl/iq_histogram.sv | 244 ++++++++++++++++++++++++
 tb/tb_iq_histogram.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/qubit_hist_pkg.sv
// Shared types and constants for the IQ histogram block.
package qubit_hist_pkg;

  localparam int unsigned HIST_ADDR_W = 10;
  localparam int unsigned MAX_BINS    = 32;
  localparam int unsigned BIN_STEPS   = 32;

  localparam logic [1:0] MODE_2D       = 2'd0;
  localparam logic [1:0] MODE_1D       = 2'd1;
  localparam logic [1:0] MODE_CLASSIFY = 2'd2;

  typedef enum logic [2:0] {
    ST_CLEAR,
    ST_IDLE,
    ST_BIN,
    ST_READ,
    ST_WRITE
  } state_e;

  // Modes 2 and 3 classify without touching the histogram RAM.
  function automatic logic mode_writes(input logic [1:0] mode);
    return mode < MODE_CLASSIFY;
  endfunction

  // An index that ran past the last bin is reported as the last bin.
  function automatic logic [4:0] clip_idx(input logic [5:0] idx);
    return idx[5] ? 5'd31 : idx[4:0];
  endfunction

endpackage

// File: rtl/hist_ram.sv
// Simple dual-port histogram RAM, registered read.
// Ports: clk; we/waddr/wdata write port; raddr -> rdata one cycle later.
module hist_ram #(
  parameter int unsigned COUNT_W = 16,
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned ADDR_W  = 10
) (
  input  logic               clk,
  input  logic               we,
  input  logic [ADDR_W-1:0]  waddr,
  input  logic [COUNT_W-1:0] wdata,
  input  logic [ADDR_W-1:0]  raddr,
  output logic [COUNT_W-1:0] rdata
);

  logic [COUNT_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/iq_histogram.sv
// 2D IQ histogram: bins each accepted point by iterative subtraction,
// accumulates saturating per-bin counts, supports host readout and clear.
// Ports: clk100/reset; iq_valid,i_val,q_val point input; binning config;
// clear_hist; rd_en/rd_addr -> rd_valid/rd_data; bin result and counters.
module iq_histogram
  import qubit_hist_pkg::*;
#(
  parameter int unsigned COUNT_W  = 16,
  parameter int unsigned MAX_BINS = 32
) (
  input  logic                   clk100,
  input  logic                   reset,
  input  logic                   iq_valid,
  input  logic [31:0]            i_val,
  input  logic [31:0]            q_val,
  input  logic [1:0]             analyze_mode,
  input  logic [15:0]            x_bin_width,
  input  logic [15:0]            y_bin_width,
  input  logic [4:0]             x_bin_num,
  input  logic [4:0]             y_bin_num,
  input  logic [15:0]            x_bin_min,
  input  logic [15:0]            y_bin_min,
  input  logic                   clear_hist,
  input  logic                   rd_en,
  input  logic [HIST_ADDR_W-1:0] rd_addr,
  output logic                   ready,
  output logic                   bin_valid,
  output logic [4:0]             bin_x,
  output logic [4:0]             bin_y,
  output logic                   in_range,
  output logic                   rd_valid,
  output logic [COUNT_W-1:0]     rd_data,
  output logic [31:0]            total_count,
  output logic [31:0]            oor_count,
  output logic [15:0]            drop_count
);

  localparam logic [4:0] LAST_STEP = 5'(BIN_STEPS - 1);

  state_e                  state_q, state_d;
  logic [HIST_ADDR_W-1:0]  clr_addr_q, clr_addr_d;
  logic                    clr_pend_q, clr_pend_d;
  logic [4:0]              step_q, step_d;
  logic                    rd_phase_q, rd_phase_d;
  logic signed [32:0]      rem_x_q, rem_x_d, rem_y_q, rem_y_d;
  logic [5:0]              idx_x_q, idx_x_d, idx_y_q, idx_y_d;
  logic [15:0]             wid_x_q, wid_x_d, wid_y_q, wid_y_d;
  logic [4:0]              num_x_q, num_x_d, num_y_q, num_y_d;
  logic                    neg_x_q, neg_x_d, neg_y_q, neg_y_d;
  logic [1:0]              mode_q, mode_d;
  logic [COUNT_W-1:0]      wdata_q, wdata_d;
  logic [4:0]              bin_x_q, bin_x_d, bin_y_q, bin_y_d;
  logic                    in_range_q, in_range_d;
  logic [31:0]             total_q, total_d, oor_q, oor_d;
  logic [15:0]             drop_q, drop_d;
  logic                    hrd_pend_q, hrd_pend_d;
  logic                    rd_valid_q, rd_valid_d;
  logic [COUNT_W-1:0]      rd_data_q, rd_data_d;

  logic                    accept, host_rd, x_ok, y_ok;
  logic [4:0]              fin_x, fin_y;
  logic                    ram_we;
  logic [HIST_ADDR_W-1:0]  ram_waddr, ram_raddr;
  logic [COUNT_W-1:0]      ram_wdata, ram_rdata;

  hist_ram #(
    .COUNT_W (COUNT_W),
    .DEPTH   (MAX_BINS * MAX_BINS),
    .ADDR_W  (HIST_ADDR_W)
  ) u_ram (
    .clk   (clk100),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  assign accept  = (state_q == ST_IDLE) && !clr_pend_q && iq_valid;
  assign host_rd = (state_q == ST_IDLE) && !clr_pend_q && !iq_valid && rd_en;

  assign x_ok  = !neg_x_q && (wid_x_q != '0) && (num_x_q != '0) &&
                 (idx_x_q < {1'b0, num_x_q});
  assign y_ok  = (mode_q == MODE_1D) ||
                 (!neg_y_q && (wid_y_q != '0) && (num_y_q != '0) &&
                  (idx_y_q < {1'b0, num_y_q}));
  assign fin_x = clip_idx(idx_x_q);
  assign fin_y = (mode_q == MODE_1D) ? '0 : clip_idx(idx_y_q);

  // State register
  always_ff @(posedge clk100) begin
    if (reset) begin
      state_q <= ST_CLEAR;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_CLEAR: if (clr_addr_q == '1) state_d = ST_IDLE;
      ST_IDLE: begin
        if (clr_pend_q)    state_d = ST_CLEAR;
        else if (iq_valid) state_d = ST_BIN;
      end
      ST_BIN:   if (step_q == LAST_STEP) state_d = ST_READ;
      ST_READ:  if (rd_phase_q) state_d = ST_WRITE;
      ST_WRITE: state_d = ST_IDLE;
      default:  state_d = ST_CLEAR;
    endcase
  end

  // Output / RAM control logic
  always_comb begin
    ready     = (state_q == ST_IDLE) && !clr_pend_q;
    bin_valid = (state_q == ST_WRITE);
    ram_we    = 1'b0;
    ram_waddr = clr_addr_q;
    ram_wdata = '0;
    ram_raddr = (state_q == ST_READ) ? {fin_y, fin_x} : rd_addr;
    if (!reset) begin
      if (state_q == ST_CLEAR) begin
        ram_we = 1'b1;
      end else if (state_q == ST_WRITE) begin
        ram_we    = in_range_q && mode_writes(mode_q);
        ram_waddr = {bin_y_q, bin_x_q};
        ram_wdata = wdata_q;
      end
    end
  end

  // Datapath next values
  always_comb begin
    clr_addr_d = (state_q == ST_CLEAR) ? clr_addr_q + HIST_ADDR_W'(1) : '0;
    step_d     = (state_q == ST_BIN) ? step_q + 5'd1 : '0;
    rd_phase_d = (state_q == ST_READ) ? ~rd_phase_q : 1'b0;

    clr_pend_d = clr_pend_q;
    if (clear_hist && (state_q != ST_CLEAR)) clr_pend_d = 1'b1;
    if ((state_q == ST_IDLE) && clr_pend_q)  clr_pend_d = 1'b0;

    rem_x_d = rem_x_q;  rem_y_d = rem_y_q;
    idx_x_d = idx_x_q;  idx_y_d = idx_y_q;
    wid_x_d = wid_x_q;  wid_y_d = wid_y_q;
    num_x_d = num_x_q;  num_y_d = num_y_q;
    neg_x_d = neg_x_q;  neg_y_d = neg_y_q;
    mode_d  = mode_q;
    wdata_d = wdata_q;
    bin_x_d = bin_x_q;  bin_y_d = bin_y_q;
    in_range_d = in_range_q;
    total_d = total_q;
    oor_d   = oor_q;
    drop_d  = drop_q;

    if (accept) begin
      rem_x_d = $signed({i_val[31], i_val}) - $signed({{17{x_bin_min[15]}}, x_bin_min});
      rem_y_d = $signed({q_val[31], q_val}) - $signed({{17{y_bin_min[15]}}, y_bin_min});
      neg_x_d = rem_x_d[32];
      neg_y_d = rem_y_d[32];
      idx_x_d = '0;
      idx_y_d = '0;
      wid_x_d = x_bin_width;
      wid_y_d = y_bin_width;
      num_x_d = x_bin_num;
      num_y_d = y_bin_num;
      mode_d  = analyze_mode;
      total_d = total_q + 32'd1;
    end

    if (state_q == ST_BIN) begin
      if (rem_x_q >= $signed({17'b0, wid_x_q})) begin
        rem_x_d = rem_x_q - $signed({17'b0, wid_x_q});
        idx_x_d = idx_x_q + 6'd1;
      end
      if (rem_y_q >= $signed({17'b0, wid_y_q})) begin
        rem_y_d = rem_y_q - $signed({17'b0, wid_y_q});
        idx_y_d = idx_y_q + 6'd1;
      end
    end

    // Second READ cycle: RAM data for the bin is valid; stage the
    // saturated increment and the published result for WRITE.
    if ((state_q == ST_READ) && rd_phase_q) begin
      wdata_d    = (ram_rdata == '1) ? ram_rdata : ram_rdata + COUNT_W'(1);
      bin_x_d    = fin_x;
      bin_y_d    = fin_y;
      in_range_d = x_ok && y_ok;
      if (!(x_ok && y_ok)) oor_d = oor_q + 32'd1;
    end

    if (state_q == ST_CLEAR) begin
      total_d = '0;
      oor_d   = '0;
    end

    if (iq_valid && !accept && (drop_q != '1)) drop_d = drop_q + 16'd1;

    hrd_pend_d = host_rd;
    rd_valid_d = hrd_pend_q;
    rd_data_d  = hrd_pend_q ? ram_rdata : rd_data_q;
  end

  always_ff @(posedge clk100) begin
    if (reset) begin
      clr_addr_q <= '0;  clr_pend_q <= 1'b0;
      step_q     <= '0;  rd_phase_q <= 1'b0;
      rem_x_q    <= '0;  rem_y_q    <= '0;
      idx_x_q    <= '0;  idx_y_q    <= '0;
      wid_x_q    <= '0;  wid_y_q    <= '0;
      num_x_q    <= '0;  num_y_q    <= '0;
      neg_x_q    <= 1'b0; neg_y_q   <= 1'b0;
      mode_q     <= '0;  wdata_q    <= '0;
      bin_x_q    <= '0;  bin_y_q    <= '0;
      in_range_q <= 1'b0;
      total_q    <= '0;  oor_q      <= '0;  drop_q <= '0;
      hrd_pend_q <= 1'b0; rd_valid_q <= 1'b0; rd_data_q <= '0;
    end else begin
      clr_addr_q <= clr_addr_d;  clr_pend_q <= clr_pend_d;
      step_q     <= step_d;      rd_phase_q <= rd_phase_d;
      rem_x_q    <= rem_x_d;     rem_y_q    <= rem_y_d;
      idx_x_q    <= idx_x_d;     idx_y_q    <= idx_y_d;
      wid_x_q    <= wid_x_d;     wid_y_q    <= wid_y_d;
      num_x_q    <= num_x_d;     num_y_q    <= num_y_d;
      neg_x_q    <= neg_x_d;     neg_y_q    <= neg_y_d;
      mode_q     <= mode_d;      wdata_q    <= wdata_d;
      bin_x_q    <= bin_x_d;     bin_y_q    <= bin_y_d;
      in_range_q <= in_range_d;
      total_q    <= total_d;     oor_q      <= oor_d;  drop_q <= drop_d;
      hrd_pend_q <= hrd_pend_d;  rd_valid_q <= rd_valid_d; rd_data_q <= rd_data_d;
    end
  end

  assign bin_x       = bin_x_q;
  assign bin_y       = bin_y_q;
  assign in_range    = in_range_q;
  assign rd_valid    = rd_valid_q;
  assign rd_data     = rd_data_q;
  assign total_count = total_q;
  assign oor_count   = oor_q;
  assign drop_count  = drop_q;

endmodule

// File: tb/tb_iq_histogram.sv
module tb_iq_histogram;

  localparam int CW = 4;

  logic          clk100 = 1'b0;
  logic          reset, iq_valid, clear_hist, rd_en;
  logic [31:0]   i_val, q_val;
  logic [1:0]    analyze_mode;
  logic [15:0]   x_bin_width, y_bin_width, x_bin_min, y_bin_min;
  logic [4:0]    x_bin_num, y_bin_num;
  logic [9:0]    rd_addr;
  logic          ready, bin_valid, in_range, rd_valid;
  logic [4:0]    bin_x, bin_y;
  logic [CW-1:0] rd_data;
  logic [31:0]   total_count, oor_count;
  logic [15:0]   drop_count;

  int unsigned pass_cnt = 0;
  int unsigned fail_cnt = 0;
  int unsigned total_cnt = 0;

  always #5 clk100 = ~clk100;

  iq_histogram #(.COUNT_W(CW), .MAX_BINS(32)) dut (
    .clk100(clk100), .reset(reset), .iq_valid(iq_valid),
    .i_val(i_val), .q_val(q_val), .analyze_mode(analyze_mode),
    .x_bin_width(x_bin_width), .y_bin_width(y_bin_width),
    .x_bin_num(x_bin_num), .y_bin_num(y_bin_num),
    .x_bin_min(x_bin_min), .y_bin_min(y_bin_min),
    .clear_hist(clear_hist), .rd_en(rd_en), .rd_addr(rd_addr),
    .ready(ready), .bin_valid(bin_valid), .bin_x(bin_x), .bin_y(bin_y),
    .in_range(in_range), .rd_valid(rd_valid), .rd_data(rd_data),
    .total_count(total_count), .oor_count(oor_count), .drop_count(drop_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk100);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic set_cfg(input logic [1:0] m, input logic [15:0] xw, input logic [15:0] yw,
                         input logic [4:0] xn, input logic [4:0] yn,
                         input logic [15:0] xmin, input logic [15:0] ymin);
    analyze_mode = m;  x_bin_width = xw; y_bin_width = yw;
    x_bin_num = xn;    y_bin_num = yn;   x_bin_min = xmin; y_bin_min = ymin;
  endtask

  // Ticks until ready returns (bounded); counts bin_valid pulses and
  // records the cycle of the last one, relative to the accept cycle.
  task automatic wait_done(input int start, output int nv, output int lat);
    int cyc;
    cyc = start; nv = 0; lat = -1;
    for (int k = 0; k < 80; k++) begin
      tick();
      cyc++;
      if (bin_valid) begin nv++; lat = cyc; end
      if (ready) break;
    end
    check("ready_back", {31'b0, ready}, 32'd1);
  endtask

  task automatic send_point(input logic [31:0] i, input logic [31:0] q,
                            output int nv, output int lat);
    i_val = i; q_val = q; iq_valid = 1'b1;
    tick();
    iq_valid = 1'b0;
    wait_done(1, nv, lat);
  endtask

  task automatic read_chk(input string tag, input logic [9:0] a, input logic [31:0] exp);
    rd_en = 1'b1; rd_addr = a;
    tick();
    rd_en = 1'b0;
    tick();
    check({tag, "_vld"}, {31'b0, rd_valid}, 32'd1);
    check(tag, {28'b0, rd_data}, exp);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nv, lat;
    reset = 1'b1; iq_valid = 1'b0; clear_hist = 1'b0; rd_en = 1'b0; rd_addr = '0;
    i_val = '0; q_val = '0;
    set_cfg(2'd0, 16'd100, 16'd100, 5'd10, 5'd10, 16'd0, 16'd0);
    ticks(3);
    check("rst_ready", {31'b0, ready}, 32'd0);
    check("rst_bin_valid", {31'b0, bin_valid}, 32'd0);
    check("rst_total", total_count, 32'd0);
    check("rst_drop", {16'b0, drop_count}, 32'd0);
    check("rst_rd_valid", {31'b0, rd_valid}, 32'd0);

    // Reset release: ready rises exactly 1024 cycles later.
    reset = 1'b0;
    ticks(1023);
    check("clr_ready_1023", {31'b0, ready}, 32'd0);
    tick();
    check("clr_ready_1024", {31'b0, ready}, 32'd1);
    read_chk("init_rd0", 10'd0, 32'd0);
    read_chk("init_rd1023", 10'd1023, 32'd0);

    // Basic 2D point, fixed latency.
    send_point(32'd250, 32'd930, nv, lat);
    check("p1_nvalid", nv, 32'd1);
    check("p1_latency", lat, 32'd35);
    check("p1_bin_x", {27'b0, bin_x}, 32'd2);
    check("p1_bin_y", {27'b0, bin_y}, 32'd9);
    check("p1_in_range", {31'b0, in_range}, 32'd1);
    check("p1_total", total_count, 32'd1);
    read_chk("p1_rd290", 10'd290, 32'd1);

    // Out-of-range cases.
    send_point(32'hFFFF_FFFF, 32'd930, nv, lat);
    check("oor_neg_in_range", {31'b0, in_range}, 32'd0);
    send_point(32'd1000, 32'd930, nv, lat);
    check("oor_high_in_range", {31'b0, in_range}, 32'd0);
    set_cfg(2'd0, 16'd0, 16'd100, 5'd10, 5'd10, 16'd0, 16'd0);
    send_point(32'd250, 32'd930, nv, lat);
    check("oor_w0_in_range", {31'b0, in_range}, 32'd0);
    set_cfg(2'd0, 16'd100, 16'd100, 5'd10, 5'd10, 16'd0, 16'd0);
    check("oor_count", oor_count, 32'd3);
    check("oor_total", total_count, 32'd4);
    read_chk("oor_rd290", 10'd290, 32'd1);

    // Strobe while busy is dropped.
    i_val = 32'd250; q_val = 32'd930; iq_valid = 1'b1;
    tick();
    iq_valid = 1'b0;
    ticks(9);
    i_val = 32'd50; q_val = 32'd50; iq_valid = 1'b1;
    tick();
    iq_valid = 1'b0;
    wait_done(11, nv, lat);
    check("drop_nvalid", nv, 32'd1);
    check("drop_count", {16'b0, drop_count}, 32'd1);
    check("drop_bin_x", {27'b0, bin_x}, 32'd2);
    read_chk("drop_rd290", 10'd290, 32'd2);
    read_chk("drop_rd0", 10'd0, 32'd0);

    // iq_valid and rd_en together: the point wins, the read is ignored.
    i_val = 32'd250; q_val = 32'd930; iq_valid = 1'b1; rd_en = 1'b1; rd_addr = 10'd290;
    tick();
    iq_valid = 1'b0; rd_en = 1'b0;
    tick();
    check("iqrd_no_rd_valid", {31'b0, rd_valid}, 32'd0);
    wait_done(2, nv, lat);
    check("iqrd_nvalid", nv, 32'd1);

    // 1D mode: y forced to bin 0 and always in range.
    set_cfg(2'd1, 16'd100, 16'd100, 5'd10, 5'd10, 16'd0, 16'd0);
    send_point(32'd350, -32'sd5000, nv, lat);
    check("m1_bin_x", {27'b0, bin_x}, 32'd3);
    check("m1_bin_y", {27'b0, bin_y}, 32'd0);
    check("m1_in_range", {31'b0, in_range}, 32'd1);

    // Classify-only mode: result reported, histogram untouched.
    set_cfg(2'd2, 16'd100, 16'd100, 5'd10, 5'd10, 16'd0, 16'd0);
    send_point(32'd250, 32'd930, nv, lat);
    check("m2_in_range", {31'b0, in_range}, 32'd1);
    check("m2_bin_y", {27'b0, bin_y}, 32'd9);
    check("m2_total", total_count, 32'd8);
    set_cfg(2'd0, 16'd100, 16'd100, 5'd10, 5'd10, 16'd0, 16'd0);

    // Back-to-back pipelined reads: 290 -> 3, 3 -> 1, 0 -> 0.
    rd_en = 1'b1; rd_addr = 10'd290;
    tick();
    rd_addr = 10'd3;
    tick();
    check("b2b_vld0", {31'b0, rd_valid}, 32'd1);
    check("b2b_d290", {28'b0, rd_data}, 32'd3);
    rd_addr = 10'd0;
    tick();
    rd_en = 1'b0;
    check("b2b_d3", {28'b0, rd_data}, 32'd1);
    tick();
    check("b2b_vld2", {31'b0, rd_valid}, 32'd1);
    check("b2b_d0", {28'b0, rd_data}, 32'd0);
    tick();
    check("b2b_vld_end", {31'b0, rd_valid}, 32'd0);

    // Saturation with a 4-bit counter: bin (9,0) -> addr 9.
    for (int n = 0; n < 14; n++) send_point(32'd950, 32'd50, nv, lat);
    read_chk("sat_rd14", 10'd9, 32'd14);
    for (int n = 0; n < 3; n++) send_point(32'd950, 32'd50, nv, lat);
    read_chk("sat_rd17", 10'd9, 32'd15);
    check("sat_total", total_count, 32'd25);
    check("sat_oor", oor_count, 32'd3);

    // clear_hist during BIN: sample completes, then a full clear sweep.
    i_val = 32'd250; q_val = 32'd930; iq_valid = 1'b1;
    tick();
    iq_valid = 1'b0;
    ticks(4);
    clear_hist = 1'b1;
    tick();
    clear_hist = 1'b0;
    nv = 0; lat = -1;
    for (int c = 7; c <= 36; c++) begin
      tick();
      if (bin_valid) begin nv++; lat = c; end
    end
    check("clrh_nvalid", nv, 32'd1);
    check("clrh_latency", lat, 32'd35);
    check("clrh_ready36", {31'b0, ready}, 32'd0);
    ticks(1024);
    check("clrh_ready_1060", {31'b0, ready}, 32'd0);
    tick();
    check("clrh_ready_1061", {31'b0, ready}, 32'd1);
    check("clrh_total", total_count, 32'd0);
    check("clrh_oor", oor_count, 32'd0);
    check("clrh_drop", {16'b0, drop_count}, 32'd1);
    read_chk("clrh_rd290", 10'd290, 32'd0);
    read_chk("clrh_rd9", 10'd9, 32'd0);
    read_chk("clrh_rd3", 10'd3, 32'd0);

    // Reset at cycle 20 of BIN: sample discarded, full clear follows.
    i_val = 32'd250; q_val = 32'd930; iq_valid = 1'b1;
    tick();
    iq_valid = 1'b0;
    ticks(19);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    nv = 0;
    for (int c = 0; c < 1023; c++) begin
      tick();
      if (bin_valid) nv++;
    end
    check("rstb_nvalid", nv, 32'd0);
    check("rstb_ready_1023", {31'b0, ready}, 32'd0);
    tick();
    check("rstb_ready_1024", {31'b0, ready}, 32'd1);
    check("rstb_total", total_count, 32'd0);
    check("rstb_drop", {16'b0, drop_count}, 32'd0);
    read_chk("rstb_rd290", 10'd290, 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
